mem_seq_ctrl: RTL and testbench
===============================

// Module: mem_seq_ctrl
// PURPOSE
//   Multi-cycle memory-instruction sequencer for the execute stage. It generalises the single-beat
//   SWP hold into a parametrised controller for SWP/SWPB (read beat then write beat) and LDM/STM
//   (one beat per set register-list bit, lowest register first). It stalls issue via o_hold and
//   drives per-beat register index, beat count and first/last flags to the regfile/LSU datapath.
// PARAMETERS
//   NUM_REGS  16                 register-list width / max beats of a block transfer
//   IDX_W     $clog2(NUM_REGS)   width of register index
//   CNT_W     $clog2(NUM_REGS+1) width of beat counter
// PORTS
//   clk         in   1         clock
//   rst_n       in   1         asynchronous active-low reset
//   en          in   1         pipeline advance; state moves only when 1 (except flush)
//   i_flush     in   1         abort current sequence (branch/exception)
//   i_vld       in   1         instruction presented in issue cycle
//   i_mode      in   2         0=single, 1=SWP, 2=LDM/STM block, 3=reserved (treated as single)
//   i_reglist   in   NUM_REGS  LDM/STM register list (ignored unless i_mode=2)
//   o_hold      out  1         stall fetch/decode; registered
//   o_swp_wr    out  1         1 = SWP write beat; registered
//   o_beat_vld  out  1         a block-transfer beat is active this cycle
//   o_beat_idx  out  IDX_W     register index of the current block beat
//   o_beat_cnt  out  CNT_W     zero-based beat number (address offset = cnt*4 downstream)
//   o_first     out  1         current beat is first of the instruction
//   o_last      out  1         current beat is last of the instruction
// BEHAVIOUR
//   - States: IDLE, SWP_WR, BLK. Reset: state=IDLE, remaining list=0, beat cnt=0, o_hold=0, o_swp_wr=0.
//   - o_hold = (state != IDLE) as a register; o_swp_wr = (state == SWP_WR) as a register.
//   - Beat outputs are combinational: in IDLE from i_vld/i_mode/i_reglist; in BLK from remaining list.
//   - IDLE, en&i_vld, mode 0/3: no transition; o_first=o_last=1, o_beat_vld=0.
//   - IDLE, en&i_vld, mode 1: issue cycle is the read beat (o_first=1, o_last=0); next state SWP_WR.
//   - SWP_WR: exactly one en-cycle long; o_first=0, o_last=1; on en -> IDLE (hold drops next cycle).
//     An i_vld in SWP_WR is not an issue (held upstream) and is ignored.
//   - IDLE, en&i_vld, mode 2: beat 0 = lowest set bit of i_reglist, o_beat_vld=1, o_beat_cnt=0, o_first=1.
//     popcount<=1 -> o_last=1, stay IDLE. popcount>=2 -> remaining = list with that bit cleared, cnt<=1, -> BLK.
//   - Empty i_reglist (mode 2): o_beat_vld=0, o_first=o_last=1, stay IDLE (no hold).
//   - BLK: o_beat_vld=1, o_beat_idx = lowest set bit of remaining, o_beat_cnt = cnt, o_first=0;
//     o_last=1 when remaining has exactly one bit. On en: clear that bit, cnt+1; if last -> IDLE.
//   - en=0 in any state: state, remaining, cnt, o_hold, o_swp_wr frozen; comb outputs stable.
//   - i_flush (independent of en): next state IDLE, o_hold<=0, o_swp_wr<=0, remaining<=0, cnt<=0.
//     Flush wins over a simultaneous i_vld issue in IDLE (nothing issued).
//   - Async reset mid-sequence: immediate return to reset values; no partial beat resumed.
//   - Max block length NUM_REGS beats; cnt never exceeds NUM_REGS-1 while o_beat_vld=1.
// TESTING
//   - SWP: en=1, i_vld=1, mode=1 -> cycle+1 o_hold=1,o_swp_wr=1,o_last=1; cycle+2 o_hold=0,o_swp_wr=0.
//   - LDM list 16'h8011: idx 0,4,15 with cnt 0,1,2; first on idx0, last on idx15; o_hold=1 for 2 cycles.
//   - Single-bit list 16'h0020 and empty list 16'h0000: o_hold never rises; idx5 vld / vld=0, first=last=1.
//   - List 16'hFFFF with en toggled 1,0,1,...: 16 beats, cnt 0..15, state frozen on every en=0 cycle.
//   - i_flush asserted on beat 2 of 16'h00FF (en=0 that cycle): next cycle IDLE, o_hold=0, cnt=0.
//   - rst_n pulsed low during BLK and during SWP_WR: outputs/regs at reset values immediately; new SWP runs cleanly after.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_seq_ctrl: multi-cycle SWP/SWPB and LDM/STM beat sequencer (execute)    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module mem_seq_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                i_flush,
    input  logic                i_vld,
    input  logic [1:0]          i_mode,
    input  logic [NUM_REGS-1:0] i_reglist,
    output logic                o_hold,
    output logic                o_swp_wr,
    output logic                o_beat_vld,
    output logic [IDX_W-1:0]    o_beat_idx,
    output logic [CNT_W-1:0]    o_beat_cnt,
    output logic                o_first,
    output logic                o_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWP_WR = 2'd1,
        BLK    = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SWP = 2'd1;
    localparam logic [1:0] MODE_BLK = 2'd2;

    state_t              state_q;
    logic [NUM_REGS-1:0] rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hold_q;
    logic                swp_wr_q;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic is_onehot(input logic [NUM_REGS-1:0] v);
        is_onehot = (v != '0) && ((v & (v - NUM_REGS'(1))) == '0);
    endfunction

    // Two's-complement trick isolates the lowest set bit of a list.
    logic [NUM_REGS-1:0] in_low_mask;
    logic [NUM_REGS-1:0] rem_low_mask;
    logic [NUM_REGS-1:0] issue_rem_d;
    logic [NUM_REGS-1:0] blk_rem_d;
    logic                in_empty;
    logic                in_single;
    logic                rem_last;

    assign in_low_mask  = i_reglist & (~i_reglist + NUM_REGS'(1));
    assign rem_low_mask = rem_q & (~rem_q + NUM_REGS'(1));
    assign issue_rem_d  = i_reglist & ~in_low_mask;
    assign blk_rem_d    = rem_q & ~rem_low_mask;
    assign in_empty     = (i_reglist == '0);
    assign in_single    = is_onehot(i_reglist);
    assign rem_last     = is_onehot(rem_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            swp_wr_q <= 1'b0;
        end else if (i_flush) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            swp_wr_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (i_vld && (i_mode == MODE_SWP)) begin
                        state_q  <= SWP_WR;
                        hold_q   <= 1'b1;
                        swp_wr_q <= 1'b1;
                    end else if (i_vld && (i_mode == MODE_BLK) && !in_empty && !in_single) begin
                        state_q <= BLK;
                        rem_q   <= issue_rem_d;
                        cnt_q   <= CNT_W'(1);
                        hold_q  <= 1'b1;
                    end
                end
                SWP_WR: begin
                    state_q  <= IDLE;
                    hold_q   <= 1'b0;
                    swp_wr_q <= 1'b0;
                end
                BLK: begin
                    rem_q <= blk_rem_d;
                    if (rem_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rem_q    <= '0;
                    cnt_q    <= '0;
                    hold_q   <= 1'b0;
                    swp_wr_q <= 1'b0;
                end
            endcase
        end
    end

    // Beat outputs follow the issuing instruction in IDLE and the remaining list in BLK.
    always_comb begin
        o_beat_vld = 1'b0;
        o_beat_idx = '0;
        o_beat_cnt = '0;
        o_first    = 1'b1;
        o_last     = 1'b1;
        case (state_q)
            IDLE: begin
                if (i_vld && (i_mode == MODE_SWP)) begin
                    o_last = 1'b0;
                end else if (i_vld && (i_mode == MODE_BLK) && !in_empty) begin
                    o_beat_vld = 1'b1;
                    o_beat_idx = lowest_idx(i_reglist);
                    o_last     = in_single;
                end
            end
            SWP_WR: begin
                o_first = 1'b0;
            end
            BLK: begin
                o_beat_vld = 1'b1;
                o_beat_idx = lowest_idx(rem_q);
                o_beat_cnt = cnt_q;
                o_first    = 1'b0;
                o_last     = rem_last;
            end
            default: begin
                o_first = 1'b1;
            end
        endcase
    end

    assign o_hold   = hold_q;
    assign o_swp_wr = swp_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_seq_ctrl: randomized and directed check against a beat-list model   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_mem_seq_ctrl;

    localparam int NUM_REGS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_vld = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [15:0] i_reglist = 16'h0;
    logic        o_hold;
    logic        o_swp_wr;
    logic        o_beat_vld;
    logic [3:0]  o_beat_idx;
    logic [4:0]  o_beat_cnt;
    logic        o_first;
    logic        o_last;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a pending SWP write beat, or a queue of register indices still to transfer.
    bit m_swp;
    int m_q[$];
    int m_cnt;

    logic [13:0] exp_v;
    logic [13:0] act_v;

    mem_seq_ctrl #(.NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i_flush(i_flush), .i_vld(i_vld),
        .i_mode(i_mode), .i_reglist(i_reglist), .o_hold(o_hold), .o_swp_wr(o_swp_wr),
        .o_beat_vld(o_beat_vld), .o_beat_idx(o_beat_idx), .o_beat_cnt(o_beat_cnt),
        .o_first(o_first), .o_last(o_last)
    );

    always #5 clk = ~clk;

    function automatic void list_to_q(input logic [15:0] l, output int q[$]);
        q = {};
        for (int i = 0; i < NUM_REGS; i++) if (l[i]) q.push_back(i);
    endfunction

    // {hold, swp_wr, beat_vld, first, last, idx[3:0], cnt[4:0]}
    function automatic logic [13:0] model_expect();
        int q[$];
        if (m_swp) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0};
        if (m_q.size() > 0)
            return {1'b1, 1'b0, 1'b1, 1'b0, (m_q.size() == 1), 4'(m_q[0]), 5'(m_cnt)};
        if (i_vld && i_mode == 2'd1) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0};
        if (i_vld && i_mode == 2'd2 && i_reglist != 16'h0) begin
            list_to_q(i_reglist, q);
            return {1'b0, 1'b0, 1'b1, 1'b1, (q.size() == 1), 4'(q[0]), 5'd0};
        end
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0};
    endfunction

    function automatic logic [13:0] pack_act(input logic ebv);
        return {o_hold, o_swp_wr, o_beat_vld, o_first, o_last,
                ebv ? o_beat_idx : 4'd0, ebv ? o_beat_cnt : 5'd0};
    endfunction

    function automatic void model_reset();
        m_swp = 1'b0;
        m_q   = {};
        m_cnt = 0;
    endfunction

    function automatic void model_clock();
        int q[$];
        if (i_flush) begin
            model_reset();
        end else if (en) begin
            if (m_swp) begin
                m_swp = 1'b0;
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
                m_cnt = (m_q.size() == 0) ? 0 : m_cnt + 1;
            end else if (i_vld && i_mode == 2'd1) begin
                m_swp = 1'b1;
            end else if (i_vld && i_mode == 2'd2) begin
                list_to_q(i_reglist, q);
                if (q.size() >= 2) begin
                    void'(q.pop_front());
                    m_q   = q;
                    m_cnt = 1;
                end
            end
        end
    endfunction

    task automatic drive(input logic e, input logic f, input logic v,
                         input logic [1:0] m, input logic [15:0] l);
        @(negedge clk);
        en = e; i_flush = f; i_vld = v; i_mode = m; i_reglist = l;
        #1;
        cyc++;
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
        exp_v = model_expect(); act_v = pack_act(exp_v[11]);
        total++;
        if (act_v !== exp_v) begin
            bad++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_swp();
        logic [1:0] modes [4] = '{2'd1, 2'd0, 2'd0, 2'd1};
        logic       vlds  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 1'b0, vlds[i], modes[i], 16'hFFFF);
            else       drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL swp cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_ldm();
        logic [15:0] lists [3] = '{16'h8011, 16'h0020, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 1'b0, (i == 0), 2'd2, lists[k]);
                exp_v = model_expect(); act_v = pack_act(exp_v[11]);
                total++;
                if (act_v !== exp_v) begin
                    bad++; $display("FAIL ldm_%h cyc=%0d got=%h want=%h", lists[k], cyc, act_v, exp_v);
                end
                advance();
            end
        end
    endtask

    task automatic test_en_toggle();
        for (int i = 0; i < 36; i++) begin
            drive((i % 2) == 0, 1'b0, (i == 0), 2'd2, 16'hFFFF);
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL en_toggle cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        // issue 00FF, two beats, then flush with en=0, then flush racing a new issue
        logic       ens [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       fls [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       vls [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive(ens[i], fls[i], vls[i], 2'd2, 16'h00FF);
            else       drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL flush cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b1, (k == 0) ? 2'd2 : 2'd1, 16'h0F0F);
            advance();
            drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
            rst_n = 1'b0;
            model_reset();
            #1;
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL reset_mid_%0d cyc=%0d got=%h want=%h", k, cyc, act_v, exp_v);
            end
            @(posedge clk); #1 rst_n = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i == 0), 2'd1, 16'h0);
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL reset_swp cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [15:0] l;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       l = 16'h0;
                1:       l = 16'hFFFF;
                2:       l = 16'(1 << $urandom_range(0, 15));
                default: l = 16'($urandom & $urandom);
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), l);
            exp_v = model_expect(); act_v = pack_act(exp_v[11]);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_swp();
        test_ldm();
        test_en_toggle();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
